// File: rtl/div3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div3_pkg : shared types, constants and elaboration helpers for div3 blocks |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CHUNK = 4;
  localparam int unsigned DIVISOR   = 3;

  function automatic bit chunk_ok(input int unsigned chunk, input int unsigned width);
    return (chunk >= 1) && (chunk <= 8) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Illegal CHUNK/WIDTH pairs divide by zero here, so they fail at elaboration.
  function automatic int unsigned calc_n(input int unsigned width, input int unsigned chunk);
    return width / (chunk_ok(chunk, width) ? chunk : 0);
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div3_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div3_seq_ctrl_if : dividend-in / result-out valid-ready handshake bundle   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface div3_seq_ctrl_if
  import div3_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [1:0]       out_remainder;

  modport slave (
    input  in_valid, in_dividend, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder
  );

  modport master (
    output in_valid, in_dividend, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder
  );
endinterface
`default_nettype wire

// File: rtl/div3_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div3_step : one digit of long division by 3 (remainder in, digit in)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module div3_step
  import div3_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  wire logic [1:0]       rem_in,
  input  wire logic [CHUNK-1:0] d,
  output logic      [CHUNK-1:0] q,
  output logic      [1:0]       rem_out
);
  localparam int unsigned C_VW = CHUNK + 2;

  logic [C_VW-1:0] w_v;

  // rem_in < 3 keeps v below 3*2^CHUNK, so the quotient digit fits CHUNK bits.
  assign w_v     = {rem_in, d};
  assign q       = CHUNK'(w_v / C_VW'(DIVISOR));
  assign rem_out = 2'(w_v % C_VW'(DIVISOR));
endmodule
`default_nettype wire

// File: rtl/div3_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div3_seq_ctrl : sequential divide-by-3, one CHUNK-bit digit per clock      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module div3_seq_ctrl
  import div3_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  div3_seq_ctrl_if.slave bus,
  output logic           busy
);
  localparam int unsigned C_N     = calc_n(WIDTH, CHUNK);
  localparam int unsigned C_CNT_W = calc_cnt_w(C_N);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_quo;
  logic [1:0]         r_rem;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out_quo;
  logic [1:0]         r_out_rem;

  logic [CHUNK-1:0]   w_qd;
  logic [1:0]         w_rem;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  div3_step #(
    .CHUNK (CHUNK)
  ) u_step (
    .rem_in  (r_rem),
    .d       (r_dvd[WIDTH-1 -: CHUNK]),
    .q       (w_qd),
    .rem_out (w_rem)
  );

  assign w_quo_nxt = (r_quo << CHUNK) | WIDTH'(w_qd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Published results live in their own registers so they survive the return to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_out_quo <= '0;
      r_out_rem <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_dvd <= bus.in_dividend;
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= C_CNT_W'(C_N - 1);
          end
        end
        RUN: begin
          r_dvd <= r_dvd << CHUNK;
          r_quo <= w_quo_nxt;
          r_rem <= w_rem;
          if (r_cnt == '0) begin
            r_out_quo <= w_quo_nxt;
            r_out_rem <= w_rem;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_quotient  = r_out_quo;
  assign bus.out_remainder = r_out_rem;
  assign busy              = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_div3_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div3_seq_ctrl : directed vector table plus handshake corner sequences   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_div3_seq_ctrl;
  localparam int unsigned C_WIDTH = 64;
  localparam int unsigned C_CHUNK = 4;
  localparam int          C_LAT   = C_WIDTH / C_CHUNK;

  typedef struct {
    logic [63:0] dvd;
    logic [63:0] q;
    logic [1:0]  r;
  } vec_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;
  int   cyc;
  bit   inv_en;

  div3_seq_ctrl_if #(.WIDTH(C_WIDTH)) bus ();

  div3_seq_ctrl #(
    .WIDTH (C_WIDTH),
    .CHUNK (C_CHUNK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (bus.out_valid && bus.in_ready) begin
        errors++;
        $display("FAIL valid_with_ready actual out_valid=1 in_ready=1 required not both");
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one dividend and counts edges from the accepting edge to out_valid.
  task automatic send_and_wait(input logic [63:0] dvd, output int lat, output bit ok);
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    bus.in_valid    = 1'b1;
    bus.in_dividend = dvd;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      lat++;
      tick();
    end
    chk("out_valid_timeout", 64'(ok), 64'd1);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[10];
    int          lat;
    bit          ok;
    logic [63:0] x;
    logic [63:0] acc[2];
    logic [63:0] resq[2];
    logic [1:0]  resr[2];
    int          nacc;
    int          nres;

    vecs[0] = '{64'd100,                  64'd33,                   2'd1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF,  64'h5555_5555_5555_5555,  2'd0};
    vecs[2] = '{64'd2,                    64'd0,                    2'd2};
    vecs[3] = '{64'd0,                    64'd0,                    2'd0};
    vecs[4] = '{64'd9,                    64'd3,                    2'd0};
    vecs[5] = '{64'd1000000,              64'd333333,               2'd1};
    vecs[6] = '{64'h8000_0000_0000_0000,  64'h2AAA_AAAA_AAAA_AAAA,  2'd2};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFE,  64'h5555_5555_5555_5554,  2'd2};
    vecs[8] = '{64'd3,                    64'd1,                    2'd0};
    vecs[9] = '{64'd5,                    64'd1,                    2'd2};

    checks          = 0;
    errors          = 0;
    cyc             = 0;
    inv_en          = 1'b0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.out_ready   = 1'b0;
    repeat (3) tick();
    rst_n  = 1'b1;
    inv_en = 1'b1;
    tick();

    chk("rst_in_ready",  64'(bus.in_ready),      64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),     64'd0);
    chk("rst_busy",      64'(busy),              64'd0);
    chk("rst_quotient",  bus.out_quotient,       64'd0);
    chk("rst_remainder", 64'(bus.out_remainder), 64'd0);

    foreach (vecs[i]) begin
      send_and_wait(vecs[i].dvd, lat, ok);
      chk("latency",     64'(lat),               64'(C_LAT));
      chk("quotient",    bus.out_quotient,       vecs[i].q);
      chk("remainder",   64'(bus.out_remainder), 64'(vecs[i].r));
      chk("done_busy",   64'(busy),              64'd1);
      release_result();
      chk("idle_ready",  64'(bus.in_ready),      64'd1);
      chk("idle_valid",  64'(bus.out_valid),     64'd0);
      chk("hold_quot",   bus.out_quotient,       vecs[i].q);
      chk("hold_rem",    64'(bus.out_remainder), 64'(vecs[i].r));
    end

    // Backpressure: result held for 20 cycles, a dividend offered meanwhile is dropped.
    send_and_wait(64'd100, lat, ok);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.in_valid    = 1'b1;
        bus.in_dividend = 64'd9;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("bp_valid",    64'(bus.out_valid),     64'd1);
      chk("bp_ready",    64'(bus.in_ready),      64'd0);
      chk("bp_quotient", bus.out_quotient,       64'd33);
      chk("bp_rem",      64'(bus.out_remainder), 64'd1);
    end
    release_result();
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_ignored_busy",  64'(busy),             64'd0);
    chk("bp_ignored_quot",  bus.out_quotient,      64'd33);

    // Reset in the middle of a computation discards it.
    bus.in_valid    = 1'b1;
    bus.in_dividend = 64'd100;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),          64'd0);
    chk("mid_rst_quot",  bus.out_quotient,   64'd0);
    send_and_wait(64'd7, lat, ok);
    chk("after_rst_lat",  64'(lat),               64'(C_LAT));
    chk("after_rst_quot", bus.out_quotient,       64'd2);
    chk("after_rst_rem",  64'(bus.out_remainder), 64'd1);
    release_result();

    // Back-to-back with in_valid held high and out_ready held high.
    nacc            = 0;
    nres            = 0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = 64'd10;
    bus.out_ready   = 1'b1;
    for (int c = 0; c < 100 && nres < 2; c++) begin
      if (bus.in_valid && bus.in_ready && nacc < 2) begin
        acc[nacc] = 64'(cyc + 1);
        nacc++;
      end
      if (bus.out_valid) begin
        resq[nres] = bus.out_quotient;
        resr[nres] = bus.out_remainder;
        nres++;
      end
      tick();
      if (nacc == 1) bus.in_dividend = 64'd11;
      if (nacc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results", 64'(nres), 64'd2);
    if (nres == 2) begin
      chk("b2b_q0",  resq[0],     64'd3);
      chk("b2b_r0",  64'(resr[0]), 64'd1);
      chk("b2b_q1",  resq[1],     64'd3);
      chk("b2b_r1",  64'(resr[1]), 64'd2);
      chk("b2b_gap", acc[1] - acc[0], 64'(C_LAT + 2));
    end
    tick();

    // Random dividends against the simulator's own division.
    for (int i = 0; i < 200; i++) begin
      x = {32'($urandom), 32'($urandom)};
      send_and_wait(x, lat, ok);
      chk("rnd_quot", bus.out_quotient,       x / 64'd3);
      chk("rnd_rem",  64'(bus.out_remainder), x % 64'd3);
      release_result();
    end

    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
